// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM channel scheduler: register map,
// commit FSM states and reset defaults.
package pwm_pkg;

    localparam logic [3:0]  ADDR_DUTY0  = 4'd0;
    localparam logic [3:0]  ADDR_TOP    = 4'd4;
    localparam logic [3:0]  ADDR_PRE    = 4'd5;
    localparam logic [3:0]  ADDR_MASK   = 4'd6;
    localparam logic [3:0]  ADDR_COMMIT = 4'd7;

    // Sliced to CNT_W bits by the user; all-ones gives a full-scale period.
    localparam logic [15:0] TOP_RST     = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } commit_state_t;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter, wrap detect and a registered
// period_start pulse. i_clr restarts the timebase from zero.
module pwm_timebase #(
    parameter int CNT_W = 8,
    parameter int PRE_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    input  logic             i_clr,
    input  logic [PRE_W-1:0] i_pre_max,
    input  logic [CNT_W-1:0] i_top,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_period_start
);

    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             r_period_start;
    logic             w_tick;
    logic             w_wrap;

    assign w_tick         = i_ena && (r_pre == i_pre_max);
    assign w_wrap         = w_tick && (r_cnt == i_top);
    assign o_cnt          = r_cnt;
    assign o_wrap         = w_wrap;
    assign o_period_start = r_period_start;

    // Prescaler and period counter; clear and disable both restart from zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre <= {PRE_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr || !i_ena) begin
            r_pre <= {PRE_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_tick) begin
            r_pre <= {PRE_W{1'b0}};
            r_cnt <= w_wrap ? {CNT_W{1'b0}} : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_pre <= r_pre + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

    // One-cycle pulse on the first cycle of each period.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
        end
    end

endmodule

// File: rtl/pwm_channel_scheduler.sv
// Multi-channel PWM with shadow/active configuration registers; a commit copies
// the whole shadow set into the active set at a period wrap so outputs never glitch.
module pwm_channel_scheduler
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int PRE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic              commit_pending
);

    commit_state_t     r_state;
    commit_state_t     w_state_nxt;
    logic              r_wr_ready;
    logic              r_commit_pending;
    logic [NUM_CH-1:0] r_pwm;
    logic [NUM_CH-1:0] w_pwm_nxt;

    logic [CNT_W-1:0]  r_duty_sh  [NUM_CH];
    logic [CNT_W-1:0]  r_duty_act [NUM_CH];
    logic [CNT_W-1:0]  r_top_sh;
    logic [CNT_W-1:0]  r_top_act;
    logic [PRE_W-1:0]  r_pre_sh;
    logic [PRE_W-1:0]  r_pre_act;
    logic [NUM_CH-1:0] r_mask_sh;
    logic [NUM_CH-1:0] r_mask_act;

    logic [CNT_W-1:0]  w_cnt;
    logic              w_wrap;
    logic              w_apply;
    logic              w_shadow_we;

    assign w_apply        = (r_state == APPLY);
    assign w_shadow_we    = wr_valid && r_wr_ready && (r_state == IDLE);
    assign wr_ready       = r_wr_ready;
    assign commit_pending = r_commit_pending;
    assign pwm_out        = r_pwm;

    pwm_timebase #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) u_timebase (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_ena          (ena),
        .i_clr          (w_apply),
        .i_pre_max      (r_pre_act),
        .i_top          (r_top_act),
        .o_cnt          (w_cnt),
        .o_wrap         (w_wrap),
        .o_period_start (period_start)
    );

    // Commit FSM next state; APPLY always lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_shadow_we && (wr_addr == ADDR_COMMIT)) begin
                    w_state_nxt = ARMED;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ARMED: begin
                if (w_wrap || !ena) begin
                    w_state_nxt = APPLY;
                end else begin
                    w_state_nxt = ARMED;
                end
            end
            APPLY:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state plus handshake/status outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_wr_ready       <= 1'b1;
            r_commit_pending <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_wr_ready       <= (w_state_nxt == IDLE);
            r_commit_pending <= (w_state_nxt != IDLE);
        end
    end

    // Shadow register file; writes are only taken while IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_sh[i] <= {CNT_W{1'b0}};
            end
            r_top_sh  <= TOP_RST[CNT_W-1:0];
            r_pre_sh  <= {PRE_W{1'b0}};
            r_mask_sh <= {NUM_CH{1'b0}};
        end else if (w_shadow_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == (ADDR_DUTY0 + 4'(i))) begin
                    r_duty_sh[i] <= wr_data[CNT_W-1:0];
                end
            end
            if (wr_addr == ADDR_TOP) begin
                r_top_sh <= wr_data[CNT_W-1:0];
            end
            if (wr_addr == ADDR_PRE) begin
                r_pre_sh <= wr_data[PRE_W-1:0];
            end
            if (wr_addr == ADDR_MASK) begin
                r_mask_sh <= wr_data[NUM_CH-1:0];
            end
        end
    end

    // Active set: atomic copy in APPLY, when the timebase is being cleared to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_act[i] <= {CNT_W{1'b0}};
            end
            r_top_act  <= TOP_RST[CNT_W-1:0];
            r_pre_act  <= {PRE_W{1'b0}};
            r_mask_act <= {NUM_CH{1'b0}};
        end else if (w_apply) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_act[i] <= r_duty_sh[i];
            end
            r_top_act  <= r_top_sh;
            r_pre_act  <= r_pre_sh;
            r_mask_act <= r_mask_sh;
        end
    end

    // Duty comparators; duty above TOP naturally yields a constant high.
    always_comb begin
        w_pwm_nxt = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            w_pwm_nxt[i] = ena && r_mask_act[i] && (w_cnt < r_duty_act[i]);
        end
    end

    // Registered PWM pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= {NUM_CH{1'b0}};
        end else begin
            r_pwm <= w_pwm_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// Self-checking bench for pwm_channel_scheduler: per-cycle comparison against a
// behavioural model of the register map, timebase and commit rules, plus literal checks.
module tb_pwm_channel_scheduler;

    localparam int NUM_CH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic [NUM_CH-1:0] pwm_out;
    logic       period_start;
    logic       commit_pending;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    pwm_channel_scheduler #(.NUM_CH(NUM_CH), .CNT_W(8), .PRE_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .commit_pending (commit_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: configuration registers, timebase position and commit phase.
    int m_pre, m_cnt, m_phase;          // phase: 0 idle, 1 waiting for wrap, 2 applying
    int sh_duty[NUM_CH], ac_duty[NUM_CH];
    int sh_top, ac_top, sh_pre, ac_pre, sh_mask, ac_mask;
    logic [NUM_CH-1:0] m_pwm;
    bit m_ps, m_ready, m_pend;
    bit m_tick, m_wrap;
    int m_next;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pre = 0; m_cnt = 0; m_phase = 0;
            for (int i = 0; i < NUM_CH; i++) begin sh_duty[i] = 0; ac_duty[i] = 0; end
            sh_top = 255; ac_top = 255; sh_pre = 0; ac_pre = 0; sh_mask = 0; ac_mask = 0;
            m_pwm = '0; m_ps = 0; m_ready = 1; m_pend = 0;
        end else begin
            m_tick = ena && (m_pre == ac_pre);
            m_wrap = m_tick && (m_cnt == ac_top);
            for (int i = 0; i < NUM_CH; i++)
                m_pwm[i] = ena && ((ac_mask >> i) & 1) && (m_cnt < ac_duty[i]);
            m_ps = m_wrap;
            m_next = m_phase;
            if (m_phase == 0) begin
                if (wr_valid && m_ready) begin
                    if (wr_addr < NUM_CH) sh_duty[wr_addr] = wr_data;
                    else if (wr_addr == 4) sh_top = wr_data;
                    else if (wr_addr == 5) sh_pre = wr_data;
                    else if (wr_addr == 6) sh_mask = wr_data & ((1 << NUM_CH) - 1);
                    else if (wr_addr == 7) m_next = 1;
                end
            end else if (m_phase == 1) begin
                if (m_wrap || !ena) m_next = 2;
            end else begin
                m_next = 0;
            end
            if (m_phase == 2 || !ena) begin
                m_pre = 0; m_cnt = 0;
            end else if (m_tick) begin
                m_pre = 0; m_cnt = m_wrap ? 0 : m_cnt + 1;
            end else begin
                m_pre = m_pre + 1;
            end
            if (m_phase == 2) begin
                for (int i = 0; i < NUM_CH; i++) ac_duty[i] = sh_duty[i];
                ac_top = sh_top; ac_pre = sh_pre; ac_mask = sh_mask;
            end
            m_phase = m_next;
            m_ready = (m_next == 0);
            m_pend  = (m_next != 0);
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
            chk("period_start", 32'(period_start), 32'(m_ps));
            chk("wr_ready", 32'(wr_ready), 32'(m_ready));
            chk("commit_pending", 32'(commit_pending), 32'(m_pend));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        int k = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        while (wr_ready !== 1'b1 && k < 2000) begin step(); k++; end
        step();
        wr_valid = 1'b0;
        chk("wr_accept_in_time", 32'(k < 2000), 32'd1);
    endtask

    task automatic wait_ps();
        int k = 0;
        do begin step(); k++; end while (period_start !== 1'b1 && k < 5000);
        chk("period_start_seen", 32'(k < 5000), 32'd1);
    endtask

    task automatic wait_applied();
        int k = 0;
        while (commit_pending !== 1'b0 && k < 5000) begin step(); k++; end
        chk("commit_applied_in_time", 32'(k < 5000), 32'd1);
    endtask

    // Period length and number of high cycles of channel 0 between two period_start pulses.
    task automatic measure(output int sp, output int hi);
        wait_ps();
        sp = 0; hi = 0;
        do begin
            hi += int'(pwm_out[0]); sp++; step();
        end while (period_start !== 1'b1 && sp < 5000);
    endtask

    int sp, hi;

    initial begin
        // 1: reset and free-running default timebase
        #1 rst = 1'b1; chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; ena = 1'b1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_pending", 32'(commit_pending), 32'd0);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        measure(sp, hi);
        chk("t1_period", 32'(sp), 32'd256);
        chk("t1_high", 32'(hi), 32'd0);

        // 2: TOP=9, PRE=0, duty0=3, ch0 enabled
        wr(4'd4, 8'd9); wr(4'd5, 8'd0); wr(4'd0, 8'd3); wr(4'd6, 8'd1); wr(4'd7, 8'd0);
        chk("t2_pending_after_commit", 32'(commit_pending), 32'd1);
        wait_applied();
        measure(sp, hi);
        chk("t2_period", 32'(sp), 32'd10);
        chk("t2_high", 32'(hi), 32'd3);

        // 3: prescale by 2, then duty above TOP, then duty zero
        wr(4'd5, 8'd1); wr(4'd7, 8'd0); wait_applied();
        measure(sp, hi);
        chk("t3_period", 32'(sp), 32'd20);
        chk("t3_high", 32'(hi), 32'd6);
        wr(4'd0, 8'd11); wr(4'd7, 8'd0); wait_applied();
        measure(sp, hi);
        chk("t3_full_high", 32'(hi), 32'd20);
        wr(4'd0, 8'd0); wr(4'd7, 8'd0); wait_applied();
        measure(sp, hi);
        chk("t3_zero_high", 32'(hi), 32'd0);

        // 4: commit while running, write held off while pending
        wr(4'd5, 8'd0); wr(4'd0, 8'd3); wr(4'd1, 8'd5); wr(4'd6, 8'd3); wr(4'd7, 8'd0);
        wait_applied();
        wr(4'd0, 8'd7); wr(4'd7, 8'd0);
        chk("t4_ready_low", 32'(wr_ready), 32'd0);
        chk("t4_pending_high", 32'(commit_pending), 32'd1);
        wr(4'd1, 8'd2);
        measure(sp, hi);
        chk("t4_period", 32'(sp), 32'd10);
        chk("t4_high", 32'(hi), 32'd7);
        wr(4'd7, 8'd0); wait_applied();

        // 5: commit accepted on the wrap edge applies one period later
        wr(4'd0, 8'd4);
        wait_ps();
        repeat (9) @(posedge clk);
        #1 wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 8'd0;
        step();
        wr_valid = 1'b0;
        chk("t5_wrap_same_cycle", 32'(period_start), 32'd1);
        chk("t5_pending", 32'(commit_pending), 32'd1);
        hi = 0;
        for (int i = 0; i < 10; i++) begin hi += int'(pwm_out[0]); step(); end
        chk("t5_old_period_high", 32'(hi), 32'd7);
        chk("t5_applying", 32'(commit_pending), 32'd1);
        wait_applied();
        measure(sp, hi);
        chk("t5_new_period", 32'(sp), 32'd10);
        chk("t5_new_high", 32'(hi), 32'd4);

        // ena low holds outputs at zero
        ena = 1'b0;
        repeat (3) step();
        chk("ena_low_pwm", 32'(pwm_out), 32'd0);
        chk("ena_low_ps", 32'(period_start), 32'd0);
        ena = 1'b1;

        // 6: asynchronous reset while armed discards the commit
        wr(4'd0, 8'd9); wr(4'd6, 8'd15); wr(4'd7, 8'd0);
        chk("t6_armed", 32'(commit_pending), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_pwm", 32'(pwm_out), 32'd0);
        chk("t6_async_ps", 32'(period_start), 32'd0);
        chk("t6_async_ready", 32'(wr_ready), 32'd1);
        chk("t6_async_pending", 32'(commit_pending), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        measure(sp, hi);
        chk("t6_period", 32'(sp), 32'd256);
        chk("t6_high", 32'(hi), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
